// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end and the press-counter FSM.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  // Debounced level is high in both states that follow an accepted press.
  function automatic logic is_high_level(key_state_e s);
    return (s == HELD) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/key_debounce_pulse_if.sv
// Button-side signals: raw key level in, clean press pulse and debounced level out.
interface key_debounce_pulse_if;
  logic key_in;
  logic x_out;
  logic level;

  modport master (output key_in, input x_out, input level);
  modport slave  (input key_in, output x_out, output level);
endinterface

// File: rtl/key_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; clears to 0 on reset.
module key_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces a raw push-button and emits one single-cycle pulse per accepted press.
module key_debounce_pulse
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  key_debounce_pulse_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  key_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             s2;
  logic             x_out_q;

  key_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.key_in),
    .q   (s2)
  );

  // cnt only advances inside a CHK state and is cleared on entry, so it stops at CNT_LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      x_out_q <= 1'b0;
    end else begin
      x_out_q <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state   <= HELD;
            x_out_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
          end
        end
        RELEASE_CHK: begin
          if (s2) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.x_out = x_out_q;
  assign bus.level = is_high_level(state);

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEBOUNCE_CYCLES=4.
module tb_key_debounce_pulse;
  import key_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  int   step_idx;
  int   pulse_count;
  int   last_pulse_idx;
  int   double_count;
  int   level_seen;
  int   ds_count;
  logic prev_x;

  key_debounce_pulse_if bus ();

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic start_window();
    step_idx       = 0;
    pulse_count    = 0;
    last_pulse_idx = -1;
    level_seen     = 0;
  endtask

  // Drive one key sample, clock it in, then observe just after the edge.
  task automatic apply_stimulus(input logic k);
    bus.key_in = k;
    @(posedge clk);
    #1;
    if (bus.x_out === 1'b1) begin
      pulse_count++;
      last_pulse_idx = step_idx;
      ds_count = (ds_count + 1) % 4;
      if (prev_x === 1'b1) double_count++;
    end
    if (bus.level === 1'b1) level_seen++;
    prev_x = bus.x_out;
    step_idx++;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    double_count = 0;
    ds_count     = 0;
    prev_x       = 1'b0;
    bus.key_in   = 1'b0;
    rst          = 1'b1;
    start_window();

    $display("[TB] reset");
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    check_output("reset_x_out", 32'(bus.x_out), 0);
    check_output("reset_level", 32'(bus.level), 0);
    check_output("reset_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0);

    $display("[TB] clean press and release");
    start_window();
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1);
      if (i == 5) begin
        check_output("clean_x_edge5", 32'(bus.x_out), 0);
        check_output("clean_level_edge5", 32'(bus.level), 0);
      end
      if (i == 6) begin
        check_output("clean_x_edge6", 32'(bus.x_out), 1);
        check_output("clean_level_edge6", 32'(bus.level), 1);
      end
      if (i == 7) check_output("clean_x_edge7", 32'(bus.x_out), 0);
    end
    check_output("clean_pulses", 32'(pulse_count), 1);
    check_output("clean_level_held", 32'(bus.level), 1);
    start_window();
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0);
      if (i == 5) check_output("release_level_edge5", 32'(bus.level), 1);
      if (i == 6) check_output("release_level_edge6", 32'(bus.level), 0);
    end
    check_output("release_pulses", 32'(pulse_count), 0);

    $display("[TB] bouncy press");
    start_window();
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b1);
      if (step_idx == 11) check_output("bouncy_level_edge10", 32'(bus.level), 0);
    end
    check_output("bouncy_pulses", 32'(pulse_count), 1);
    check_output("bouncy_pulse_edge", 32'(last_pulse_idx), 11);

    $display("[TB] bouncy release");
    start_window();
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0);
      if (step_idx == 8) check_output("bounce_rel_level_edge7", 32'(bus.level), 1);
      if (step_idx == 9) check_output("bounce_rel_level_edge8", 32'(bus.level), 0);
    end
    check_output("bounce_rel_pulses", 32'(pulse_count), 0);

    $display("[TB] long hold");
    start_window();
    ds_count = 1;
    for (int i = 0; i < 1000; i++) apply_stimulus(1'b1);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1);
    check_output("long_pulses", 32'(pulse_count), 2);
    check_output("long_counter", 32'(ds_count), 3);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0);

    $display("[TB] reset during press check");
    start_window();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1);
    rst = 1'b1;
    apply_stimulus(1'b1);
    check_output("rst_x_out", 32'(bus.x_out), 0);
    check_output("rst_level", 32'(bus.level), 0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(1'b1);
      if (step_idx == 7) check_output("rst_no_pulse_edge6", 32'(bus.x_out), 0);
    end
    check_output("rst_pulses", 32'(pulse_count), 1);
    check_output("rst_pulse_edge", 32'(last_pulse_idx), 11);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0);

    $display("[TB] glitch rejection");
    start_window();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0);
    check_output("glitch3_pulses", 32'(pulse_count), 0);
    check_output("glitch3_level", 32'(level_seen), 0);
    check_output("glitch3_state", 32'(dut.state), 32'(IDLE));
    start_window();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0);
    check_output("glitch4_pulses", 32'(pulse_count), 0);
    start_window();
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0);
    check_output("high5_pulses", 32'(pulse_count), 1);
    check_output("high5_pulse_edge", 32'(last_pulse_idx), 6);

    check_output("no_double_pulse", 32'(double_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
